// File: rtl/feature_row_cache_ctrl.sv
// rtl/feature_row_cache_ctrl.sv - frame sequencer feeding a 3-row feature row cache
// Latches frame geometry, paces source beats into the cache and tags each beat with its column/row.
module feature_row_cache_ctrl #(
  parameter int COL_W = 10
) (
  input  logic             system_clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [COL_W-1:0] cfg_col_size,
  input  logic [COL_W-1:0] cfg_row_size,
  input  logic             cfg_rebuild,
  input  logic             abort,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             cache_wr_en,
  output logic [COL_W-1:0] cache_col_size,
  output logic             cache_rebuild,
  output logic             win_valid,
  output logic [COL_W-1:0] win_col,
  output logic [COL_W-1:0] win_row,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [COL_W-1:0] ONE   = COL_W'(1);
  localparam logic [COL_W-1:0] TWO   = COL_W'(2);
  localparam logic [COL_W-1:0] THREE = COL_W'(3);

  logic [1:0]       state;
  logic [COL_W-1:0] col_cnt;
  logic [COL_W-1:0] row_cnt;
  logic [COL_W-1:0] row_size;
  logic             cfg_ok;
  logic             last_col;
  logic             last_row;

  assign cfg_ok   = (cfg_col_size != '0) && (cfg_row_size >= THREE);
  assign last_col = (col_cnt == cache_col_size - ONE);
  assign last_row = (row_cnt == row_size - ONE);

  // Abort blocks acceptance in its own cycle so no beat slips into a discarded frame.
  assign src_ready   = (state == S_RUN) && !abort;
  assign cache_wr_en = src_valid && src_ready;
  assign win_valid   = cache_wr_en && (row_cnt >= TWO);
  assign win_col     = col_cnt;
  assign win_row     = row_cnt;
  assign busy        = (state != S_IDLE);
  assign frame_done  = (state == S_DONE) && !abort;

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      col_cnt        <= '0;
      row_cnt        <= '0;
      row_size       <= '0;
      cache_col_size <= '0;
      cache_rebuild  <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (abort && state != S_IDLE) begin
        state   <= S_IDLE;
        col_cnt <= '0;
        row_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cfg_start && !abort) begin
              if (cfg_ok) begin
                cache_col_size <= cfg_col_size;
                row_size       <= cfg_row_size;
                cache_rebuild  <= cfg_rebuild;
                state          <= S_PRIME;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          S_PRIME: state <= S_RUN;
          S_RUN: begin
            if (cache_wr_en) begin
              if (last_col) begin
                col_cnt <= '0;
                if (last_row) begin
                  row_cnt <= '0;
                  state   <= S_DONE;
                end else begin
                  row_cnt <= row_cnt + ONE;
                end
              end else begin
                col_cnt <= col_cnt + ONE;
              end
            end
          end
          default: begin
            state   <= S_IDLE;
            col_cnt <= '0;
            row_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_feature_row_cache_ctrl.sv
// tb/tb_feature_row_cache_ctrl.sv - self-checking bench for feature_row_cache_ctrl
// Beat-count model checked every cycle, plus directed scenarios with literal counts.
module tb_feature_row_cache_ctrl;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_start;
  logic [W-1:0] cfg_col_size;
  logic [W-1:0] cfg_row_size;
  logic         cfg_rebuild;
  logic         abort;
  logic         src_valid;
  logic         src_ready;
  logic         cache_wr_en;
  logic [W-1:0] cache_col_size;
  logic         cache_rebuild;
  logic         win_valid;
  logic [W-1:0] win_col;
  logic [W-1:0] win_row;
  logic         busy;
  logic         frame_done;
  logic         cfg_err;

  always #5 clk = ~clk;

  feature_row_cache_ctrl #(.COL_W(W)) dut (
    .system_clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_col_size(cfg_col_size), .cfg_row_size(cfg_row_size), .cfg_rebuild(cfg_rebuild),
    .abort(abort), .src_valid(src_valid), .src_ready(src_ready), .cache_wr_en(cache_wr_en),
    .cache_col_size(cache_col_size), .cache_rebuild(cache_rebuild), .win_valid(win_valid),
    .win_col(win_col), .win_row(win_row), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: a frame is just a beat count k; column = k mod cols, row = k div cols.
  int m_ph = 0;  // 0 idle, 1 prime, 2 run, 3 done
  int m_k = 0, m_cols = 0, m_rows = 0, m_reb = 0, m_err = 0;
  int e_busy, e_rdy, e_wr, e_win, e_done, e_err, e_col, e_row, e_csz, e_reb;
  int cyc = 0, st_cyc = 0, lat = -1, armed = 0;
  int n_wr = 0, n_win = 0, n_done = 0, n_err = 0;
  int winq[$];

  always @(negedge clk) begin
    cyc++;
    e_col = 0; e_row = 0; e_rdy = 0; e_wr = 0; e_win = 0; e_done = 0;
    if (!rst_n) begin
      e_busy = 0; e_err = 0; e_csz = 0; e_reb = 0;
    end else begin
      e_busy = (m_ph != 0) ? 1 : 0;
      e_err  = m_err;
      e_csz  = m_cols;
      e_reb  = m_reb;
      e_done = (m_ph == 3 && !abort) ? 1 : 0;
      if (m_ph == 2) begin
        e_rdy = abort ? 0 : 1;
        e_wr  = (e_rdy == 1 && src_valid) ? 1 : 0;
        e_col = m_k % m_cols;
        e_row = m_k / m_cols;
        e_win = (e_wr == 1 && e_row >= 2) ? 1 : 0;
      end
    end
    chk("busy", busy, e_busy);
    chk("src_ready", src_ready, e_rdy);
    chk("cache_wr_en", cache_wr_en, e_wr);
    chk("win_valid", win_valid, e_win);
    chk("frame_done", frame_done, e_done);
    chk("cfg_err", cfg_err, e_err);
    chk("cache_col_size", cache_col_size, e_csz);
    chk("cache_rebuild", cache_rebuild, e_reb);
    if (e_wr == 1 || !rst_n) begin
      chk("win_col", win_col, e_col);
      chk("win_row", win_row, e_row);
    end
    if (cache_wr_en) n_wr++;
    if (win_valid) begin n_win++; winq.push_back(int'(win_row) * 16 + int'(win_col)); end
    if (frame_done) n_done++;
    if (cfg_err) n_err++;
    if (rst_n && cfg_start && !busy) begin st_cyc = cyc; armed = 1; end
    else if (armed == 1 && cache_wr_en) begin lat = cyc - st_cyc; armed = 0; end
    if (!rst_n) begin
      m_ph = 0; m_k = 0; m_cols = 0; m_rows = 0; m_reb = 0; m_err = 0;
    end else begin
      m_err = 0;
      case (m_ph)
        0: if (!abort && cfg_start) begin
             if (cfg_col_size >= 1 && cfg_row_size >= 3) begin
               m_cols = cfg_col_size; m_rows = cfg_row_size; m_reb = cfg_rebuild;
               m_ph = 1; m_k = 0;
             end else m_err = 1;
           end
        1: m_ph = abort ? 0 : 2;
        2: if (abort) begin m_ph = 0; m_k = 0; end
           else if (e_wr == 1) begin
             m_k++;
             if (m_k == m_cols * m_rows) m_ph = 3;
           end
        default: begin m_ph = 0; m_k = 0; end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int c, input int r, input logic reb);
    cfg_col_size = W'(c); cfg_row_size = W'(r); cfg_rebuild = reb;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk(nm, (n < 200) ? 1 : 0, 1);
  endtask

  int b_wr, b_win, b_done, b_err, bq;
  task automatic snap();
    b_wr = n_wr; b_win = n_win; b_done = n_done; b_err = n_err; bq = winq.size();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_col_size = '0; cfg_row_size = '0;
    cfg_rebuild = 1'b0; abort = 1'b0; src_valid = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_col_size", cache_col_size, 0);
    rst_n = 1'b1;
    tick();

    // continuous frame 4x3
    snap(); src_valid = 1'b1;
    start(4, 3, 1'b1);
    wait_idle("s1_timeout");
    src_valid = 1'b0;
    chk("s1_wr", n_wr - b_wr, 12);
    chk("s1_win", n_win - b_win, 4);
    chk("s1_done", n_done - b_done, 1);
    chk("s1_latency", lat, 2);
    for (int i = 0; i < 4; i++) chk("s1_win_pos", (winq.size() > bq + i) ? winq[bq + i] : -1, 32 + i);
    chk("s1_rebuild_held", cache_rebuild, 1);

    // stall frame 3x4, src_valid toggling
    snap();
    start(3, 4, 1'b0);
    begin
      int n = 0;
      while (busy && n < 200) begin src_valid = ~src_valid; tick(); n++; end
      chk("s2_timeout", (n < 200) ? 1 : 0, 1);
    end
    src_valid = 1'b0;
    chk("s2_wr", n_wr - b_wr, 12);
    chk("s2_win", n_win - b_win, 6);
    chk("s2_done", n_done - b_done, 1);

    // illegal configurations
    snap();
    start(5, 2, 1'b1);
    repeat (2) tick();
    start(0, 5, 1'b1);
    repeat (2) tick();
    chk("s3_err", n_err - b_err, 2);
    chk("s3_col_size", cache_col_size, 3);
    chk("s3_rebuild", cache_rebuild, 0);
    chk("s3_busy", busy, 0);

    // cfg_start during RUN is ignored
    snap(); src_valid = 1'b1;
    start(4, 3, 1'b0);
    repeat (5) tick();
    start(2, 5, 1'b1);
    wait_idle("s4_timeout");
    chk("s4_wr", n_wr - b_wr, 12);
    chk("s4_win", n_win - b_win, 4);
    chk("s4_done", n_done - b_done, 1);
    chk("s4_err", n_err - b_err, 0);
    chk("s4_col_size", cache_col_size, 4);

    // abort on beat 5, then a clean 2x3 frame
    snap();
    start(4, 3, 1'b1);
    tick();
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("s5_busy", busy, 0);
    chk("s5_wr", n_wr - b_wr, 4);
    chk("s5_done", n_done - b_done, 0);
    snap();
    start(2, 3, 1'b0);
    wait_idle("s5b_timeout");
    chk("s5b_wr", n_wr - b_wr, 6);
    chk("s5b_done", n_done - b_done, 1);
    chk("s5b_win0", (winq.size() > bq) ? winq[bq] : -1, 32);
    chk("s5b_win1", (winq.size() > bq + 1) ? winq[bq + 1] : -1, 33);

    // reset mid-run
    snap();
    start(4, 3, 1'b1);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("s6_busy", busy, 0);
    chk("s6_ready", src_ready, 0);
    chk("s6_wr", cache_wr_en, 0);
    chk("s6_col_size", cache_col_size, 0);
    chk("s6_win_col", win_col, 0);
    chk("s6_rebuild", cache_rebuild, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    src_valid = 1'b0;
    chk("s6_idle", busy, 0);
    chk("s6_done", n_done - b_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
